// File: rtl/seq_det_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg
// Shared defaults for the parameterised serial pattern detector and a helper
// that sizes the fill counter.
//   DEF_PAT_W    : default pattern length in bits
//   DEF_RST_PAT  : default pattern loaded at reset
//   DEF_CNT_W    : default match-counter width
//   DEF_OVERLAP  : default match mode (1 = overlapping)
//   fill_width() : bits needed to hold a fill count in 0..pat_w
// ---------------------------------------------------------------------------
package seq_det_pkg;

  localparam int         DEF_PAT_W   = 3;
  localparam logic [2:0] DEF_RST_PAT = 3'b101;
  localparam int         DEF_CNT_W   = 8;
  localparam int         DEF_OVERLAP = 1;

  // The fill counter must reach pat_w itself, hence pat_w + 1 states.
  function automatic int fill_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear. A clear coincident with an
// increment leaves the counter at 1, so the event on that edge is not lost.
//   clk : clock, rising edge active
//   rst : asynchronous active-low reset (q -> 0)
//   clr : synchronous clear
//   inc : count one event
//   q   : current count, sticks at all-ones
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= inc ? W'(1) : '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// ---------------------------------------------------------------------------
// seq_detect_param
// Runtime-programmable serial pattern detector. Enabled input bits shift into
// a PAT_W-bit history register; a fill counter records how many fresh bits the
// history holds so stale contents can never match. A match raises a one-cycle
// registered pulse on out and bumps a saturating match counter.
//   clk       : clock, rising edge active
//   rst       : asynchronous active-low reset
//   in        : serial data bit, sampled when en=1
//   en        : sample enable
//   pat       : new pattern (MSB = oldest bit)
//   pat_load  : load pat, restart fill; takes priority over en
//   clr_cnt   : synchronous clear of match_cnt
//   out       : match pulse, one cycle after the completing sample edge
//   match_cnt : saturating number of matches
// ---------------------------------------------------------------------------
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(DEF_RST_PAT),
  parameter int               OVERLAP = DEF_OVERLAP,
  parameter int               CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             en,
  input  logic [PAT_W-1:0] pat,
  input  logic             pat_load,
  input  logic             clr_cnt,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int               FILL_W = fill_width(PAT_W);
  localparam logic [FILL_W-1:0] FULL  = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  sh;
  logic [PAT_W-1:0]  sh_nxt;
  logic [PAT_W-1:0]  pat_reg;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_inc;
  logic              sample;
  logic              hit;

  // Match is judged on the post-update history and fill, so the pulse lines
  // up with the edge that sampled the completing bit.
  always_comb begin
    sample   = en & ~pat_load;
    sh_nxt   = {sh[PAT_W-2:0], in};
    fill_inc = (fill == FULL) ? FULL : fill + 1'b1;
    hit      = sample && (fill_inc == FULL) && (sh_nxt == pat_reg);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh      <= '0;
      fill    <= '0;
      pat_reg <= RST_PAT;
      out     <= 1'b0;
    end else begin
      if (pat_load) begin
        // History bits stay put but are no longer trusted: fill restarts.
        pat_reg <= pat;
        fill    <= '0;
      end else if (en) begin
        sh <= sh_nxt;
        // Non-overlapping mode forgets the bits that formed the match.
        if (hit && (OVERLAP == 0)) begin
          fill <= '0;
        end else begin
          fill <= fill_inc;
        end
      end
      out <= hit;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt),
    .inc (hit),
    .q   (match_cnt)
  );

endmodule

// File: tb/tb_seq_detect_param.sv
// ---------------------------------------------------------------------------
// tb_seq_detect_param
// Three detector instances share one stimulus stream:
//   a : PAT_W=3, reset pattern 101, overlapping,     CNT_W=8
//   b : PAT_W=3, reset pattern 101, non-overlapping, CNT_W=8
//   c : PAT_W=3, reset pattern 101, overlapping,     CNT_W=2
// A behavioural model tracks, per instance, the number of fresh bits and the
// integer value of the last three bits; out and match_cnt are compared on
// every falling edge, and literal expectations pin the directed scenarios.
// ---------------------------------------------------------------------------
module tb_seq_detect_param;

  localparam int PW   = 3;
  localparam int MASK = (1 << PW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          d_in   = 1'b0;
  logic          d_en   = 1'b0;
  logic [PW-1:0] d_pat  = '0;
  logic          d_pl   = 1'b0;
  logic          d_clr  = 1'b0;

  logic       out_a, out_b, out_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;

  seq_detect_param #(.PAT_W(3), .RST_PAT(3'b101), .OVERLAP(1), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .in(d_in), .en(d_en), .pat(d_pat), .pat_load(d_pl),
    .clr_cnt(d_clr), .out(out_a), .match_cnt(cnt_a));

  seq_detect_param #(.PAT_W(3), .RST_PAT(3'b101), .OVERLAP(0), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .in(d_in), .en(d_en), .pat(d_pat), .pat_load(d_pl),
    .clr_cnt(d_clr), .out(out_b), .match_cnt(cnt_b));

  seq_detect_param #(.PAT_W(3), .RST_PAT(3'b101), .OVERLAP(1), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .in(d_in), .en(d_en), .pat(d_pat), .pat_load(d_pl),
    .clr_cnt(d_clr), .out(out_c), .match_cnt(cnt_c));

  // ---------------- counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int ovl_of(input int i);
    return (i == 1) ? 0 : 1;
  endfunction

  function automatic int max_of(input int i);
    return (i == 2) ? 3 : 255;
  endfunction

  int m_pat      = 5;             // 3'b101
  int m_fresh[3] = '{0, 0, 0};    // enabled bits since last restart
  int m_win[3]   = '{0, 0, 0};    // last three bits as a number
  int m_out[3]   = '{0, 0, 0};
  int m_cnt[3]   = '{0, 0, 0};

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pat = 5;
      for (int i = 0; i < 3; i++) begin
        m_fresh[i] = 0;
        m_win[i]   = 0;
        m_out[i]   = 0;
        m_cnt[i]   = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        int hit;
        hit = 0;
        if (d_pl) begin
          m_fresh[i] = 0;
        end else if (d_en) begin
          m_win[i] = ((m_win[i] * 2) + int'(d_in)) & MASK;
          m_fresh[i]++;
          if (m_fresh[i] >= PW && m_win[i] == m_pat) begin
            hit = 1;
            if (ovl_of(i) == 0) m_fresh[i] = 0;
          end
        end
        m_out[i] = hit;
        if (d_clr) m_cnt[i] = hit;
        else if (hit == 1 && m_cnt[i] < max_of(i)) m_cnt[i]++;
      end
      if (d_pl) m_pat = int'(d_pat);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("out_a", int'(out_a), m_out[0]);
    check("out_b", int'(out_b), m_out[1]);
    check("out_c", int'(out_c), m_out[2]);
    check("cnt_a", int'(cnt_a), m_cnt[0]);
    check("cnt_b", int'(cnt_b), m_cnt[1]);
    check("cnt_c", int'(cnt_c), m_cnt[2]);
  end

  // ---------------- driver ----------------
  task automatic step(input logic b, input logic e, input logic pl = 1'b0,
                      input logic [PW-1:0] p = '0, input logic clr = 1'b0);
    d_in  = b;
    d_en  = e;
    d_pl  = pl;
    d_pat = p;
    d_clr = clr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bits(input int n, input logic [15:0] v);
    for (int i = n - 1; i >= 0; i--) step(v[i], 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    repeat (2) @(negedge clk);
    check("rst_out_a", int'(out_a), 0);
    check("rst_cnt_a", int'(cnt_a), 0);
    check("rst_cnt_c", int'(cnt_c), 0);
    rst = 1'b1;

    // 1,0,1,0,1 against reset pattern 101
    step(1, 1); step(0, 1); step(1, 1);
    check("ov_3rd_a", int'(out_a), 1);
    check("nov_3rd_b", int'(out_b), 1);
    step(0, 1);
    check("ov_4th_a", int'(out_a), 0);
    step(1, 1);
    check("ov_5th_a", int'(out_a), 1);
    check("nov_5th_b", int'(out_b), 0);
    check("ov_cnt_a", int'(cnt_a), 2);
    check("nov_cnt_b", int'(cnt_b), 1);

    // Stale history equal to the new pattern must not match
    bits(2, 16'b11);                 // history now 111
    step(0, 1'b0, 1'b1, 3'b111);     // load 111, fill restarts
    step(1, 1);
    check("stale_1_a", int'(out_a), 0);
    step(1, 1);
    check("stale_2_a", int'(out_a), 0);
    step(1, 1);
    check("stale_3_a", int'(out_a), 1);
    check("stale_3_b", int'(out_b), 1);

    // Pattern 110; load edge also carries en=1 which must be ignored
    step(1, 1'b1, 1'b1, 3'b110);
    check("load_out_a", int'(out_a), 0);
    bits(3, 16'b110);
    check("p110_3rd_a", int'(out_a), 1);
    step(1, 1);
    check("p110_old101_a", int'(out_a), 0);
    bits(2, 16'b10);
    check("p110_6th_a", int'(out_a), 1);
    check("p110_6th_b", int'(out_b), 1);

    // Enable gaps between 1 and 0,1
    step(0, 1'b0, 1'b1, 3'b101);
    step(1, 1);
    step(0, 0);
    check("gap1_out_a", int'(out_a), 0);
    step(0, 1);
    step(1, 0);
    check("gap2_out_a", int'(out_a), 0);
    step(0, 0);
    check("gap3_out_a", int'(out_a), 0);
    step(1, 1);
    check("gap_match_a", int'(out_a), 1);
    check("gap_match_b", int'(out_b), 1);

    // Clear alone
    step(0, 0, 0, '0, 1'b1);
    check("clr_cnt_a", int'(cnt_a), 0);
    check("clr_cnt_c", int'(cnt_c), 0);

    // Saturation on the 2-bit counter: five matches, then clear + 6th match
    step(0, 0, 1'b1, 3'b101);
    bits(11, 16'b10101010101);
    check("sat_cnt_c", int'(cnt_c), 3);
    check("sat_cnt_a", int'(cnt_a), 5);
    step(0, 1);
    step(1, 1, 0, '0, 1'b1);
    check("clrhit_cnt_c", int'(cnt_c), 1);
    check("clrhit_cnt_a", int'(cnt_a), 1);
    check("clrhit_cnt_b", int'(cnt_b), 0);

    // Asynchronous reset mid-stream
    bits(2, 16'b10);
    #2 rst = 1'b0;
    #1;
    check("arst_out_a", int'(out_a), 0);
    check("arst_cnt_a", int'(cnt_a), 0);
    check("arst_cnt_c", int'(cnt_c), 0);
    @(negedge clk);
    rst = 1'b1;
    step(1, 1);
    check("post_rst_1_a", int'(out_a), 0);
    bits(2, 16'b01);
    check("post_rst_101_a", int'(out_a), 1);
    check("post_rst_cnt_a", int'(cnt_a), 1);

    // Randomised tail, checked by the model only
    for (int k = 0; k < 150; k++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 19) == 0), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 15) == 0));
    end
    step(0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL have parameter PAT_W, default 3, meaning pattern length in bits (legal range 2..32).
REQ-002 SHALL have parameter RST_PAT, default 3'b101 (PAT_W bits), meaning the pattern loaded at reset.
REQ-003 SHALL have parameter OVERLAP, default 1, meaning 1 = overlapping matches allowed, 0 = non-overlapping.
REQ-004 SHALL have parameter CNT_W, default 8, meaning match-counter width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port in, input, 1 bit: the serial data bit, sampled on clk rising edge when en=1.
REQ-008 SHALL have port en, input, 1 bit: sample enable.
REQ-009 SHALL have port pat, input, PAT_W bits: the new pattern, MSB = oldest bit.
REQ-010 SHALL have port pat_load, input, 1 bit: loads pat into the pattern register.
REQ-011 SHALL have port clr_cnt, input, 1 bit: synchronous clear of match_cnt.
REQ-012 SHALL have port out, output, 1 bit: registered one-cycle match pulse.
REQ-013 SHALL have port match_cnt, output, CNT_W bits: saturating count of matches.

Function
REQ-014 SHALL hold a PAT_W-bit history shift register (sh), a fill counter (fill, 0..PAT_W), and a pattern register (pat_reg).
REQ-015 On an edge with en=1 and pat_load=0: sh <= {sh[PAT_W-2:0], in}; fill increments, saturating at PAT_W.
REQ-016 The match condition is: post-update fill == PAT_W and post-update sh == pat_reg.
REQ-017 out SHALL be registered and asserted exactly in the cycle following the edge that sampled the completing bit (latency 1 clock from the sampling edge); otherwise out=0.
REQ-018 With OVERLAP=1, fill SHALL remain PAT_W after a match, so a suffix of the match may start the next one.
REQ-019 With OVERLAP=0, fill SHALL be set to 0 on a match, so the next match needs PAT_W fresh bits.
REQ-020 When en=0 and pat_load=0: sh, fill and pat_reg SHALL hold, and out=0 the next cycle.
REQ-021 When pat_load=1: pat_reg <= pat, fill <= 0, out <= 0; in is not sampled that edge; pat_load has priority over en.
REQ-022 match_cnt SHALL increment by 1 per match and saturate at all-ones (no wrap).
REQ-023 When clr_cnt=1 and a match occur on the same edge, match_cnt SHALL become 1; clr_cnt alone sets it to 0.
REQ-024 Bits received before fill reaches PAT_W SHALL never produce a match, including when the stale sh bits equal pat_reg.

Reset
REQ-025 While rst=0, regardless of clk: sh=0, fill=0, pat_reg=RST_PAT, out=0, match_cnt=0.
REQ-026 Reset asserted mid-stream SHALL discard the partial history; the first match after release requires PAT_W new enabled bits.
REQ-027 Deassertion SHALL be synchronised externally; the block treats the first rising clk edge with rst=1 as a normal cycle.

Structure
REQ-028 A shared package seq_det_pkg SHALL hold default constants: DEF_PAT_W=3, DEF_RST_PAT=3'b101, DEF_CNT_W=8.
REQ-029 The match counter SHALL be a sub-module sat_counter (parameter W; inputs clk, rst, clr, inc; output q) implementing REQ-022 and REQ-023.
REQ-030 The detector SHALL use the shift-register-plus-fill architecture, not a hand-coded per-pattern FSM, so that pat stays runtime-programmable.

Verification
REQ-031 Reset defaults, OVERLAP=1, en=1, in = 1,0,1,0,1 -> out pulses after the 3rd and 5th bits; match_cnt=2.
REQ-032 OVERLAP=0, same stream 1,0,1,0,1 -> out pulses after the 3rd bit only; match_cnt=1.
REQ-033 pat_load with pat=3'b110, then in = 1,1,0,1,1,0 -> out pulses after the 3rd and 6th bits; the old 101 never matches.
REQ-034 en toggled low between the bits 1 and 0,1 -> gaps are ignored and a match still occurs after the final 1; out=0 in every en=0 cycle.
REQ-035 CNT_W=2, five matches -> match_cnt stops at 3; clr_cnt coincident with the 6th match -> match_cnt=1.
REQ-036 rst pulsed low after in = 1,0 -> out=0 and match_cnt=0 immediately (asynchronous); a following single 1 gives no match, and 1,0,1 gives a match.
